game_sprite_launcher: RTL and testbench

Command-side sequencer that drives the write/enable interface of a sprite motion controller (sprite_write_xy, sprite_write_dxy, sprite_enable_update and the data buses). On a launch request it samples a start position and velocity, then issues a two-cycle load sequence. After that it enables free motion for a bounded lifetime, supports pause, stop and optional auto-respawn, and counts launches. It sits between game logic and the per-sprite motion controller.

---
 rtl/game_sprite_launcher.sv | 158 +++++++++++++++
 tb/tb_game_sprite_launcher.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sprite_launcher.sv
// Launch sequencer for a sprite motion controller: two-cycle load, timed run,
// pause, stop, optional auto-respawn and a saturating launch counter.
module game_sprite_launcher #(
  parameter int screen_width    = 640,
  parameter int screen_height   = 480,
  parameter int w_x             = $clog2(screen_width),
  parameter int w_y             = $clog2(screen_height),
  parameter int DX_WIDTH        = 2,
  parameter int DY_WIDTH        = 2,
  parameter int LIFETIME_CYCLES = 1000000,
  parameter int RESPAWN_DELAY   = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                launch,
  input  logic                stop,
  input  logic                pause,
  input  logic                auto_relaunch,
  input  logic [w_x-1:0]      start_x,
  input  logic [w_y-1:0]      start_y,
  input  logic [DX_WIDTH-1:0] start_dx,
  input  logic [DY_WIDTH-1:0] start_dy,
  output logic                sprite_write_xy,
  output logic                sprite_write_dxy,
  output logic [w_x-1:0]      sprite_write_x,
  output logic [w_y-1:0]      sprite_write_y,
  output logic [DX_WIDTH-1:0] sprite_write_dx,
  output logic [DY_WIDTH-1:0] sprite_write_dy,
  output logic                sprite_enable_update,
  output logic                active,
  output logic                expired,
  output logic [7:0]          launch_count
);

  localparam int LW =
    (LIFETIME_CYCLES > 1) ? $clog2(LIFETIME_CYCLES) : 1;
  localparam int RW =
    (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;
  localparam logic [LW-1:0] LIFE_LAST = LW'(LIFETIME_CYCLES - 1);
  localparam logic [RW-1:0] RESP_LAST = RW'(RESPAWN_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_XY,
    LOAD_DXY,
    RUN,
    PAUSED,
    RESPAWN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [LW-1:0] life_cnt;
  logic [LW-1:0] life_n;
  logic [RW-1:0] resp_cnt;
  logic [RW-1:0] resp_n;
  logic          expire_n;
  logic          bump;
  logic          accept;

  assign accept = launch & ~stop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      life_cnt <= '0;
      resp_cnt <= '0;
    end else begin
      state    <= state_n;
      life_cnt <= life_n;
      resp_cnt <= resp_n;
    end
  end

  // stop beats launch, launch beats any timer expiry, expiry beats pause
  always_comb begin
    state_n  = state;
    life_n   = life_cnt;
    resp_n   = resp_cnt;
    expire_n = 1'b0;
    bump     = 1'b0;
    if (stop) begin
      state_n = IDLE;
    end else if (launch) begin
      state_n = LOAD_XY;
      bump    = 1'b1;
    end else begin
      unique case (state)
        IDLE: state_n = IDLE;
        LOAD_XY: state_n = LOAD_DXY;
        LOAD_DXY: begin
          state_n = RUN;
          life_n  = '0;
        end
        RUN: begin
          if (life_cnt == LIFE_LAST) begin
            state_n  = RESPAWN;
            expire_n = 1'b1;
            resp_n   = '0;
          end else begin
            life_n = life_cnt + 1'b1;
            if (pause) state_n = PAUSED;
          end
        end
        PAUSED: begin
          if (!pause) state_n = RUN;
        end
        RESPAWN: begin
          if (resp_cnt == RESP_LAST) begin
            if (auto_relaunch) begin
              state_n = LOAD_XY;
              bump    = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            resp_n = resp_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // outputs registered from the next state so they align with the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sprite_write_xy      <= 1'b0;
      sprite_write_dxy     <= 1'b0;
      sprite_enable_update <= 1'b0;
      active               <= 1'b0;
      expired              <= 1'b0;
      launch_count         <= '0;
      sprite_write_x       <= '0;
      sprite_write_y       <= '0;
      sprite_write_dx      <= '0;
      sprite_write_dy      <= '0;
    end else begin
      sprite_write_xy      <= (state_n == LOAD_XY);
      sprite_write_dxy     <= (state_n == LOAD_DXY);
      sprite_enable_update <= (state_n == RUN);
      active               <= (state_n == LOAD_XY) ||
                              (state_n == LOAD_DXY) ||
                              (state_n == RUN) ||
                              (state_n == PAUSED);
      expired              <= expire_n;
      if (bump && launch_count != 8'hFF)
        launch_count <= launch_count + 8'd1;
      if (accept) begin
        sprite_write_x  <= start_x;
        sprite_write_y  <= start_y;
        sprite_write_dx <= start_dx;
        sprite_write_dy <= start_dy;
      end
    end
  end

endmodule

// File: tb/tb_game_sprite_launcher.sv
// Directed bench for game_sprite_launcher with short lifetime/respawn
// timers so whole run/respawn cycles fit in a few dozen clocks.
module tb_game_sprite_launcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       launch = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       auto_relaunch = 1'b0;
  logic [9:0] start_x = '0;
  logic [8:0] start_y = '0;
  logic [1:0] start_dx = '0;
  logic [1:0] start_dy = '0;
  logic       xy;
  logic       dxy;
  logic [9:0] wx;
  logic [8:0] wy;
  logic [1:0] wdx;
  logic [1:0] wdy;
  logic       en;
  logic       act;
  logic       exp_p;
  logic [7:0] cnt;

  int total = 0;
  int bad = 0;

  game_sprite_launcher #(
    .LIFETIME_CYCLES(10),
    .RESPAWN_DELAY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .launch(launch),
    .stop(stop),
    .pause(pause),
    .auto_relaunch(auto_relaunch),
    .start_x(start_x),
    .start_y(start_y),
    .start_dx(start_dx),
    .start_dy(start_dy),
    .sprite_write_xy(xy),
    .sprite_write_dxy(dxy),
    .sprite_write_x(wx),
    .sprite_write_y(wy),
    .sprite_write_dx(wdx),
    .sprite_write_dy(wdy),
    .sprite_enable_update(en),
    .active(act),
    .expired(exp_p),
    .launch_count(cnt)
  );

  always #5 clk = ~clk;

  task step;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    launch = 0;
    stop = 0;
    pause = 0;
    auto_relaunch = 0;
    rst = 0;
    step;
    step;
    rst = 1;
    step;
  endtask

  task fire(input logic [9:0] x, input logic [8:0] y,
            input logic [1:0] dx, input logic [1:0] dy);
    start_x = x;
    start_y = y;
    start_dx = dx;
    start_dy = dy;
    launch = 1;
    step;
    launch = 0;
  endtask

  task test_reset;
    rst = 1;
    #2;
    rst = 0;
    #1;
    total++;
    if ({xy, dxy, en, act, exp_p} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000",
               {xy, dxy, en, act, exp_p});
    end
    total++;
    if (cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", cnt);
    end
    total++;
    if ({wx, wy, wdx, wdy} !== 23'd0) begin
      bad++;
      $display("FAIL reset_bus: got %0h want 0", {wx, wy, wdx, wdy});
    end
    step;
    step;
    rst = 1;
    step;
  endtask

  task test_launch;
    do_reset;
    fire(10'd100, 9'd200, 2'd1, 2'd3);
    total++;
    if ({xy, dxy, en} !== 3'b100) begin
      bad++;
      $display("FAIL launch_c1: got %b want 100", {xy, dxy, en});
    end
    total++;
    if (wx !== 10'd100 || wy !== 9'd200) begin
      bad++;
      $display("FAIL launch_xy: got %0d/%0d want 100/200", wx, wy);
    end
    total++;
    if (act !== 1'b1 || cnt !== 8'd1) begin
      bad++;
      $display("FAIL launch_act_cnt: got %b/%0d want 1/1", act, cnt);
    end
    step;
    total++;
    if ({xy, dxy, en} !== 3'b010) begin
      bad++;
      $display("FAIL launch_c2: got %b want 010", {xy, dxy, en});
    end
    total++;
    if (wdx !== 2'd1 || wdy !== 2'd3) begin
      bad++;
      $display("FAIL launch_dxy: got %0d/%0d want 1/3", wdx, wdy);
    end
    step;
    total++;
    if ({xy, dxy, en, act} !== 4'b0011) begin
      bad++;
      $display("FAIL launch_c3: got %b want 0011", {xy, dxy, en, act});
    end
  endtask

  task test_lifetime;
    int en_cnt;
    int ex_cnt;
    int ex_i;
    int last_en;
    int xy_cnt;
    en_cnt = 0;
    ex_cnt = 0;
    ex_i = -1;
    last_en = -1;
    xy_cnt = 0;
    do_reset;
    fire(10'd100, 9'd200, 2'd1, 2'd3);
    for (int i = 0; i < 30; i++) begin
      if (en) begin
        en_cnt++;
        last_en = i;
      end
      if (exp_p) begin
        ex_cnt++;
        ex_i = i;
      end
      if (xy) xy_cnt++;
      step;
    end
    total++;
    if (en_cnt !== 10) begin
      bad++;
      $display("FAIL life_en_cycles: got %0d want 10", en_cnt);
    end
    total++;
    if (ex_cnt !== 1 || ex_i !== 12) begin
      bad++;
      $display("FAIL life_expired: got n=%0d at %0d want n=1 at 12",
               ex_cnt, ex_i);
    end
    total++;
    if (last_en !== 11) begin
      bad++;
      $display("FAIL life_last_en: got %0d want 11", last_en);
    end
    total++;
    if (xy_cnt !== 1 || act !== 1'b0) begin
      bad++;
      $display("FAIL life_idle: got xy=%0d act=%b want 1/0", xy_cnt, act);
    end
  endtask

  task test_auto;
    int idx;
    do_reset;
    auto_relaunch = 1;
    fire(10'd100, 9'd200, 2'd1, 2'd3);
    start_x = 10'd300;
    start_y = 9'd50;
    start_dx = 2'd2;
    start_dy = 2'd0;
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      if (xy && i > 0) begin
        idx = i;
        break;
      end
      step;
    end
    total++;
    if (idx !== 16) begin
      bad++;
      $display("FAIL auto_timing: got %0d want 16", idx);
    end
    total++;
    if (wx !== 10'd100 || wy !== 9'd200) begin
      bad++;
      $display("FAIL auto_xy: got %0d/%0d want 100/200", wx, wy);
    end
    total++;
    if (cnt !== 8'd2) begin
      bad++;
      $display("FAIL auto_cnt: got %0d want 2", cnt);
    end
    step;
    total++;
    if (dxy !== 1'b1 || wdx !== 2'd1 || wdy !== 2'd3) begin
      bad++;
      $display("FAIL auto_dxy: got %b %0d/%0d want 1 1/3", dxy, wdx, wdy);
    end
    auto_relaunch = 0;
    stop = 1;
    step;
    stop = 0;
    total++;
    if ({xy, dxy, en, act} !== 4'b0) begin
      bad++;
      $display("FAIL auto_stop: got %b want 0000", {xy, dxy, en, act});
    end
  endtask

  task test_pause;
    int en_cnt;
    int low;
    int strobes;
    en_cnt = 0;
    low = 0;
    strobes = 0;
    do_reset;
    fire(10'd100, 9'd200, 2'd1, 2'd3);
    step;
    step;
    en_cnt += int'(en);
    repeat (3) begin
      step;
      en_cnt += int'(en);
    end
    pause = 1;
    repeat (5) begin
      step;
      if (!en) low++;
      if (xy || dxy) strobes++;
    end
    pause = 0;
    repeat (20) begin
      step;
      en_cnt += int'(en);
    end
    total++;
    if (low !== 5) begin
      bad++;
      $display("FAIL pause_low: got %0d want 5", low);
    end
    total++;
    if (strobes !== 0) begin
      bad++;
      $display("FAIL pause_strobes: got %0d want 0", strobes);
    end
    total++;
    if (en_cnt !== 10) begin
      bad++;
      $display("FAIL pause_en_total: got %0d want 10", en_cnt);
    end
  endtask

  task test_stop_launch;
    int strobes;
    strobes = 0;
    do_reset;
    fire(10'd100, 9'd200, 2'd1, 2'd3);
    step;
    step;
    step;
    stop = 1;
    launch = 1;
    start_x = 10'd7;
    start_y = 9'd8;
    step;
    stop = 0;
    launch = 0;
    total++;
    if ({xy, dxy, en, act} !== 4'b0) begin
      bad++;
      $display("FAIL stop_ctl: got %b want 0000", {xy, dxy, en, act});
    end
    total++;
    if (cnt !== 8'd1 || wx !== 10'd100) begin
      bad++;
      $display("FAIL stop_nolatch: got %0d/%0d want 1/100", cnt, wx);
    end
    repeat (5) begin
      step;
      if (xy || dxy || en) strobes++;
    end
    total++;
    if (strobes !== 0) begin
      bad++;
      $display("FAIL stop_quiet: got %0d want 0", strobes);
    end
    fire(10'd100, 9'd200, 2'd1, 2'd3);
    step;
    total++;
    if (dxy !== 1'b1) begin
      bad++;
      $display("FAIL relaunch_pre: got %b want 1", dxy);
    end
    fire(10'd5, 9'd6, 2'd2, 2'd1);
    total++;
    if ({xy, dxy, en} !== 3'b100 || wx !== 10'd5 || wy !== 9'd6) begin
      bad++;
      $display("FAIL relaunch_dxy: got %b %0d/%0d want 100 5/6",
               {xy, dxy, en}, wx, wy);
    end
    total++;
    if (cnt !== 8'd3) begin
      bad++;
      $display("FAIL relaunch_cnt: got %0d want 3", cnt);
    end
  endtask

  task test_expiry_launch;
    do_reset;
    fire(10'd100, 9'd200, 2'd1, 2'd3);
    step;
    step;
    repeat (9) step;
    total++;
    if (en !== 1'b1) begin
      bad++;
      $display("FAIL exp_last_run: got %b want 1", en);
    end
    launch = 1;
    step;
    launch = 0;
    total++;
    if ({xy, en, exp_p} !== 3'b100 || cnt !== 8'd2) begin
      bad++;
      $display("FAIL exp_launch: got %b cnt=%0d want 100 cnt=2",
               {xy, en, exp_p}, cnt);
    end
    step;
    total++;
    if (dxy !== 1'b1 || exp_p !== 1'b0) begin
      bad++;
      $display("FAIL exp_launch_dxy: got %b%b want 10", dxy, exp_p);
    end
  endtask

  task test_reset_mid;
    int strobes;
    strobes = 0;
    do_reset;
    fire(10'd100, 9'd200, 2'd1, 2'd3);
    #2;
    rst = 0;
    #1;
    total++;
    if ({xy, dxy, en, act, exp_p} !== 5'b0 || cnt !== 8'd0 ||
        wx !== 10'd0 || wy !== 9'd0) begin
      bad++;
      $display("FAIL mid_reset: got %b cnt=%0d x=%0d want 0",
               {xy, dxy, en, act, exp_p}, cnt, wx);
    end
    step;
    step;
    rst = 1;
    repeat (6) begin
      step;
      if (xy || dxy || en || act) strobes++;
    end
    total++;
    if (strobes !== 0) begin
      bad++;
      $display("FAIL mid_reset_quiet: got %0d want 0", strobes);
    end
  endtask

  task test_saturate;
    do_reset;
    start_x = 10'd1;
    launch = 1;
    repeat (260) step;
    launch = 0;
    total++;
    if (cnt !== 8'd255) begin
      bad++;
      $display("FAIL sat_cnt: got %0d want 255", cnt);
    end
    step;
    fire(10'd2, 9'd3, 2'd0, 2'd0);
    total++;
    if (cnt !== 8'd255 || xy !== 1'b1) begin
      bad++;
      $display("FAIL sat_hold: got %0d xy=%b want 255 1", cnt, xy);
    end
  endtask

  initial begin
    test_reset;
    test_launch;
    test_lifetime;
    test_auto;
    test_pause;
    test_stop_launch;
    test_expiry_launch;
    test_reset_mid;
    test_saturate;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
